// File: rtl/lb_pkg.sv
// Shared types and constants for the local-bus command arbiter.
package lb_pkg;

  typedef struct packed {
    logic [7:0]  op;
    logic [23:0] addr;
    logic [31:0] data;
  } lb_cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} lb_state_e;

  localparam logic [7:0]  OP_WR      = 8'h00;
  localparam logic [7:0]  OP_RD      = 8'h01;
  localparam logic [7:0]  OP_SYNC    = 8'hff;
  localparam logic [31:0] ST_TIMEOUT = 32'hffffffff;
  localparam logic [31:0] ST_ILLEGAL = 32'hdeadbeef;

  // Only writes and reads reach the local bus.
  function automatic logic fwd_op(input logic [7:0] op);
    return (op == OP_WR) || (op == OP_RD);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; the favoured requester is updated by the
// caller once a granted transaction completes.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic [1:0] gnt
);

  logic pri;  // requester that wins when both request

  always_ff @(posedge clk) begin
    if (rst)      pri <= 1'b0;
    else if (upd) pri <= ~upd_id;
  end

  assign gnt[0] = req[0] & (~req[1] | ~pri);
  assign gnt[1] = req[1] & (~req[0] |  pri);

endmodule

// File: rtl/lb_cmd_arb.sv
// Two-requester arbiter/sequencer for the shared 64-bit local-bus command
// port: one command in flight, response routed back to its originator.
module lb_cmd_arb
  import lb_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] req_cmd0,
  input  logic        req_valid0,
  output logic        req_ready0,
  output logic [63:0] resp_data0,
  output logic        resp_valid0,
  input  logic [63:0] req_cmd1,
  input  logic        req_valid1,
  output logic        req_ready1,
  output logic [63:0] resp_data1,
  output logic        resp_valid1,
  output logic [63:0] lb_cmd,
  output logic        lb_valid,
  input  logic [31:0] lb_rdata,
  input  logic        lb_rvalid,
  output logic        busy,
  output logic [15:0] err_cnt
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  lb_state_e     state;
  lb_cmd_t       cmd, in_cmd, rsp;
  logic          gid, done, err_inc, accept;
  logic [1:0]    gnt;
  logic [CW-1:0] cnt;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req_valid1, req_valid0}),
    .upd    (state == RESP),
    .upd_id (gid),
    .gnt    (gnt)
  );

  assign accept     = (state == IDLE) && !rst;
  assign req_ready0 = accept & gnt[0];
  assign req_ready1 = accept & gnt[1];
  assign in_cmd     = gnt[1] ? lb_cmd_t'(req_cmd1) : lb_cmd_t'(req_cmd0);
  assign busy       = (state != IDLE);

  // done: the response is final this cycle and RESP follows.
  always_comb begin
    done    = 1'b0;
    err_inc = 1'b0;
    rsp     = cmd;
    case (state)
      ISSUE: begin
        case (cmd.op)
          OP_WR:   done = 1'b1;
          OP_RD:   done = 1'b0;
          OP_SYNC: begin
            done     = 1'b1;
            rsp.addr = '1;
          end
          default: begin
            done     = 1'b1;
            err_inc  = 1'b1;
            rsp.data = ST_ILLEGAL;
          end
        endcase
      end
      WAIT_RD: begin
        // read data beats the timeout when both land together
        if (lb_rvalid) begin
          done     = 1'b1;
          rsp.data = lb_rdata;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          done     = 1'b1;
          err_inc  = 1'b1;
          rsp.data = ST_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd         <= '0;
      gid         <= 1'b0;
      cnt         <= '0;
      lb_cmd      <= '0;
      lb_valid    <= 1'b0;
      resp_data0  <= '0;
      resp_data1  <= '0;
      resp_valid0 <= 1'b0;
      resp_valid1 <= 1'b0;
      err_cnt     <= '0;
    end else begin
      lb_valid    <= 1'b0;
      resp_valid0 <= 1'b0;
      resp_valid1 <= 1'b0;
      if (err_inc && err_cnt != 16'hffff) err_cnt <= err_cnt + 16'd1;
      if (done) begin
        state <= RESP;
        if (gid) begin
          resp_valid1 <= 1'b1;
          resp_data1  <= rsp;
        end else begin
          resp_valid0 <= 1'b1;
          resp_data0  <= rsp;
        end
      end
      case (state)
        IDLE: begin
          if (|gnt) begin
            cmd   <= in_cmd;
            gid   <= gnt[1];
            state <= ISSUE;
            if (fwd_op(in_cmd.op)) begin
              lb_valid <= 1'b1;
              lb_cmd   <= in_cmd;
            end
          end
        end
        ISSUE: begin
          cnt <= '0;
          if (!done) state <= WAIT_RD;
        end
        WAIT_RD: cnt   <= cnt + CW'(1);
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lb_cmd_arb.sv
// Randomized scoreboard bench for lb_cmd_arb with a transaction-level model.
module tb_lb_cmd_arb;

  localparam int TO = 16;

  logic        clk = 1'b0, rst = 1'b1;
  logic [63:0] req_cmd0 = '0, req_cmd1 = '0;
  logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic        req_ready0, req_ready1, resp_valid0, resp_valid1;
  logic [63:0] resp_data0, resp_data1, lb_cmd;
  logic        lb_valid, busy;
  logic [31:0] lb_rdata = '0;
  logic        lb_rvalid = 1'b0;
  logic [15:0] err_cnt;

  lb_cmd_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_cmd0(req_cmd0), .req_valid0(req_valid0), .req_ready0(req_ready0),
    .resp_data0(resp_data0), .resp_valid0(resp_valid0),
    .req_cmd1(req_cmd1), .req_valid1(req_valid1), .req_ready1(req_ready1),
    .resp_data1(resp_data1), .resp_valid1(resp_valid1),
    .lb_cmd(lb_cmd), .lb_valid(lb_valid), .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [63:0] data; int cyc; } exp_t;
  typedef struct { logic [63:0] cmd; int n; logic [31:0] rd; int cyc; } lbx_t;

  exp_t        exp0[$], exp1[$];
  lbx_t        lb_q[$];
  bit          gnt_log[$];
  int          checks = 0, errors = 0;
  logic [15:0] err_exp = '0;
  logic [63:0] last0 = '0, last1 = '0;
  logic        last_g = 1'b1;
  logic [63:0] c0, c1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  // Present one command, wait for acceptance, and record what must follow.
  task automatic issue(input int id, input logic [63:0] c, input int n, input logic [31:0] rd);
    bit   got = 0;
    exp_t e;
    logic [7:0] op;
    if (id == 0) begin req_valid0 = 1'b1; req_cmd0 = c; end
    else         begin req_valid1 = 1'b1; req_cmd1 = c; end
    for (int w = 0; w < 400 && !got; w++) begin
      #1;
      if (id == 0 ? req_ready0 : req_ready1) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      chk($sformatf("grant_timeout%0d", id), 64'(got), 64'd1);
    end else begin
      op     = c[63:56];
      e.data = c;
      e.cyc  = cyc + 2;
      if (op == 8'h01) begin
        if (n >= 1 && n <= TO) begin
          e.data[31:0] = rd;
          e.cyc        = cyc + n + 2;
        end else begin
          e.data[31:0] = 32'hffffffff;
          e.cyc        = cyc + TO + 2;
          err_exp      = sat_inc(err_exp);
        end
      end else if (op == 8'hff) begin
        e.data[63:32] = 32'hffffffff;
      end else if (op != 8'h00) begin
        e.data[31:0] = 32'hdeadbeef;
        err_exp      = sat_inc(err_exp);
      end
      if (op == 8'h00 || op == 8'h01) lb_q.push_back('{c, n, rd, cyc + 1});
      if (id == 0) exp0.push_back(e); else exp1.push_back(e);
      @(negedge clk);
    end
    if (id == 0) begin req_valid0 = 1'b0; req_cmd0 = {$urandom, $urandom}; end
    else         begin req_valid1 = 1'b0; req_cmd1 = {$urandom, $urandom}; end
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || lb_q.size() != 0 || busy) && w < 300) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    chk("drain_timeout", 64'(w < 300), 64'd1);
    chk("err_cnt", 64'(err_cnt), 64'(err_exp));
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  function automatic logic [63:0] rnd_cmd();
    int r = $urandom_range(0, 9);
    logic [7:0] op;
    if (r < 4)       op = 8'h00;
    else if (r < 8)  op = 8'h01;
    else if (r == 8) op = 8'hff;
    else             op = 8'($urandom_range(2, 254));
    return {op, 24'($urandom), $urandom};
  endfunction

  function automatic int rnd_n(input logic [63:0] c);
    logic [7:0] op = c[63:56];
    return (op == 8'h01) ? int'($urandom_range(0, TO + 1)) : int'($urandom_range(0, 1));
  endfunction

  task automatic chk_resp(input int id, input logic [63:0] d, input logic [63:0] other);
    exp_t e;
    if ((id == 0 && exp0.size() == 0) || (id == 1 && exp1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_resp%0d: got %h expected none (cycle %0d)", id, d, cyc);
      return;
    end
    if (id == 0) e = exp0.pop_front(); else e = exp1.pop_front();
    chk($sformatf("resp%0d_data", id), d, e.data);
    chk($sformatf("resp%0d_cycle", id), 64'(cyc), 64'(e.cyc));
    chk($sformatf("resp%0d_other_hold", id), other, (id == 0) ? last1 : last0);
    if (id == 0) last0 = e.data; else last1 = e.data;
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid0) chk_resp(0, resp_data0, resp_data1);
      if (resp_valid1) chk_resp(1, resp_data1, resp_data0);
    end
  end

  // Grant monitor: single grant, lone requester wins, else the one not granted last.
  always begin
    logic [1:0] g;
    @(negedge clk);
    #2;
    if (!rst && (req_ready0 || req_ready1)) begin
      g = (req_valid0 && req_valid1) ? (last_g ? 2'b01 : 2'b10) : {req_valid1, req_valid0};
      chk("grant", 64'({req_ready1, req_ready0}), 64'(g));
      last_g = req_ready1;
      gnt_log.push_back(req_ready1);
    end
  end

  // Local-bus monitor and responder.
  initial begin
    lbx_t l;
    forever begin
      @(negedge clk);
      if (!rst && lb_valid) begin
        if (lb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_lb_valid: got %h expected none (cycle %0d)", lb_cmd, cyc);
        end else begin
          l = lb_q.pop_front();
          chk("lb_cmd", lb_cmd, l.cmd);
          chk("lb_cycle", 64'(cyc), 64'(l.cyc));
          if ((l.cmd[63:56] == 8'h01 && l.n > 0) || (l.cmd[63:56] == 8'h00 && l.n == 1)) begin
            repeat (l.n) @(negedge clk);
            lb_rvalid = 1'b1;
            lb_rdata  = l.rd;
            @(negedge clk);
            lb_rvalid = 1'b0;
            lb_rdata  = $urandom;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'({req_ready1, req_ready0}), 64'd0);
    chk("rst_lb", 64'({lb_valid, busy, resp_valid1, resp_valid0}), 64'd0);
    chk("rst_lb_cmd", lb_cmd, 64'd0);
    chk("rst_resp0", resp_data0, 64'd0);
    chk("rst_resp1", resp_data1, 64'd0);
    chk("rst_err", 64'(err_cnt), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // single write, then read answered after 5 cycles
    issue(0, 64'h0000000900000000, 0, 32'h0);
    wait_idle();
    issue(1, 64'h0100001700e02281, 5, 32'hfacefeed);
    wait_idle();
    chk("read_resp_data", last1, 64'h01000017facefeed);

    // both requesters busy: four writes each, grants alternate from 0
    gnt_log.delete();
    fork
      for (int k = 0; k < 4; k++) issue(0, {8'h00, 24'(16 + k), $urandom}, 0, 32'h0);
      for (int k = 0; k < 4; k++) issue(1, {8'h00, 24'(32 + k), $urandom}, 0, 32'h0);
    join
    wait_idle();
    chk("rr_count", 64'(gnt_log.size()), 64'd8);
    if (gnt_log.size() == 8) begin
      chk("rr_first", 64'(gnt_log[0]), 64'd0);
      for (int i = 1; i < 8; i++) chk("rr_alternate", 64'(gnt_log[i]), 64'(!gnt_log[i-1]));
    end

    // read timeout, then data exactly on the timeout cycle
    issue(0, {8'h01, 24'h000123, 32'h0}, 0, 32'h0);
    wait_idle();
    chk("timeout_resp", last0, {8'h01, 24'h000123, 32'hffffffff});
    issue(1, {8'h01, 24'h000124, 32'h0}, TO, 32'h13572468);
    wait_idle();
    chk("timeout_edge_resp", last1, {8'h01, 24'h000124, 32'h13572468});

    // sync marker and illegal opcode
    issue(1, {8'hff, 24'h000abc, 32'h12345678}, 0, 32'h0);
    wait_idle();
    chk("sync_resp", last1, 64'hffffffff12345678);
    issue(0, {8'h42, 24'h000def, 32'h11111111}, 0, 32'h0);
    wait_idle();
    chk("illegal_resp", last0, {8'h42, 24'h000def, 32'hdeadbeef});

    // reset while waiting for read data; the data then arrives late
    issue(0, {8'h01, 24'h000055, 32'h0}, 8, 32'h5a5a5a5a);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp0.delete();
    exp1.delete();
    err_exp = '0;
    last_g  = 1'b1;
    last0   = '0;
    last1   = '0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_err", 64'(err_cnt), 64'd0);
    repeat (10) @(negedge clk);
    chk("late_rvalid_busy", 64'(busy), 64'd0);
    issue(1, {8'h00, 24'h000777, 32'hcafef00d}, 0, 32'h0);
    wait_idle();

    // randomized traffic from both requesters
    fork
      for (int k = 0; k < 15; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        c0 = rnd_cmd();
        issue(0, c0, rnd_n(c0), $urandom);
      end
      for (int k = 0; k < 15; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        c1 = rnd_cmd();
        issue(1, c1, rnd_n(c1), $urandom);
      end
    join
    wait_idle();
    repeat (TO + 4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lb_cmd_arb.md
Name: lb_cmd_arb

Overview:
- Two-requester arbiter and sequencer for the shared 64-bit local-bus command port.
- Requester 0 is the UART command path; requester 1 is the UDP (udplb64) command path.
- Accepts one command at a time, issues it to the local bus and waits for read data where required, then routes the response back to the originating requester.
- Sits between the host-interface front ends and the lbreg register file, inside qubichw_config.

Parameters:
- TIMEOUT, 1024: local-bus clk cycles to wait for lb_rvalid before aborting a read.
- OP_WR, 8'h00: write opcode.
- OP_RD, 8'h01: read opcode.
- OP_SYNC, 8'hff: sync/marker opcode; consumed, never forwarded.

Ports:
- clk  in  1  local-bus clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_cmd0  in  64  requester 0 command {op[63:56], addr[55:32], data[31:0]}.
- req_valid0  in  1  requester 0 command valid.
- req_ready0  out  1  requester 0 command accepted this cycle.
- resp_data0  out  64  response to requester 0 {op, addr, rdata-or-status}.
- resp_valid0  out  1  single-cycle response strobe to requester 0.
- req_cmd1, req_valid1, req_ready1, resp_data1, resp_valid1: same as above, for requester 1.
- lb_cmd  out  64  command to local bus.
- lb_valid  out  1  single-cycle command strobe.
- lb_rdata  in  32  read data from local bus.
- lb_rvalid  in  1  read data strobe.
- busy  out  1  high in any state other than IDLE.
- err_cnt  out  16  saturating count of timeouts plus illegal opcodes.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer favours requester 0.
- FSM states are IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - If exactly one req_valid is high, grant that requester.
  - If both are high, grant the requester that was not granted last.
  - On grant, req_ready of the granted requester is high for exactly one cycle; latch the command and the grant id. Go to ISSUE next cycle.
  - Never assert both req_ready outputs in the same cycle.
- ISSUE, op==OP_WR:
  - lb_cmd = latched command; lb_valid=1 for one cycle.
  - Next state is RESP, with response {op, addr, data}.
- ISSUE, op==OP_RD:
  - lb_valid=1 for one cycle; start the timeout counter at 0.
  - Next state is WAIT_RD.
- ISSUE, op==OP_SYNC:
  - No lb_valid. Response {8'hff, 24'hffffff, latched data}.
  - Next state is RESP.
- ISSUE, any other op:
  - No lb_valid; err_cnt increments; response {op, addr, 32'hdeadbeef}.
  - Next state is RESP.
- WAIT_RD:
  - lb_rvalid: capture lb_rdata; response {op, addr, lb_rdata}; go to RESP.
  - Counter reaches TIMEOUT-1 without lb_rvalid: err_cnt increments; response {op, addr, 32'hffffffff}; go to RESP.
  - lb_rvalid on the same cycle as the timeout: data wins; no error counted.
- lb_rvalid outside WAIT_RD is ignored.
- RESP:
  - resp_valid of the granted requester is high for one cycle with its resp_data.
  - Flip the round-robin pointer to the other requester; return to IDLE.
  - resp_data of the non-granted requester holds its previous value.
- Latency:
  - Write: accept to lb_valid is 1 cycle; accept to resp_valid is 2 cycles.
  - Read: resp_valid is 1 cycle after lb_rvalid.
- Only one command is outstanding at a time.
- Requesters hold req_valid/req_cmd until req_ready. Deasserting req_valid before grant is legal; nothing is issued.
- err_cnt saturates at 16'hffff.
- rst asserted mid-transaction: FSM returns to IDLE next cycle; no response is emitted; a pending read is discarded. err_cnt resets to 0.

Decomposition:
- Shared package lb_pkg holds:
  - typedef lb_cmd_t, a packed struct {op 8, addr 24, data 32};
  - the opcode constants;
  - the timeout and illegal-op status constants (32'hffffffff, 32'hdeadbeef).
- One sub-module, rr_arb2: two-input round-robin grant with a pointer-update input. Everything else lives in lb_cmd_arb.

Test Plan:
- Write from requester 0: req_cmd0=64'h0000000900000000.
  - Required: lb_valid 1 cycle after accept with the same lb_cmd.
  - Required: resp_valid0 2 cycles after accept; resp_valid1 stays 0.
- Read from requester 1: req_cmd1=64'h0100001700e02281; bench returns lb_rdata=32'hfacefeed after 5 cycles.
  - Required: resp_data1=64'h01000017facefeed one cycle after lb_rvalid.
- Both requesters valid every cycle, four writes each.
  - Required: grants alternate 0,1,0,1,...
  - Required: never two req_ready in one cycle; 8 lb_valid pulses in order.
- Read with no lb_rvalid, TIMEOUT=16.
  - Required: resp_data low word 32'hffffffff, 17 cycles after lb_valid.
  - Required: err_cnt=1.
  - Variant: lb_rvalid on the timeout cycle gives real data and err_cnt=0.
- Op 8'hff, then op 8'h42.
  - Required: no lb_valid for either.
  - Required: sync response high bits 32'hffffffff.
  - Required: 8'h42 response low word 32'hdeadbeef; err_cnt=1.
- rst pulsed during WAIT_RD.
  - Required: no resp_valid; busy=0 next cycle.
  - Required: a late lb_rvalid is ignored.
  - Required: the next command completes normally.
